// File: rtl/button_request.sv
// -----------------------------------------------------------------------------
// button_request
//
// Front end that turns a raw, bouncing push-button into clean write requests
// for the LED walker's request bus. At most one request is outstanding.
//
// Pipeline:
//   i_btn -> 2-FF synchronizer -> integrating debouncer (o_btn)
//         -> registered rising-edge detector (press)
//         -> request FSM (o_cyc / o_stb / o_we), accept counter, drop flag
//
// Ports:
//   i_clk      system clock, the only clock
//   i_reset    asynchronous, active-high reset
//   i_btn      raw button, asynchronous to i_clk, may bounce
//   i_stall    downstream stall; a request is accepted on any edge where
//              o_stb && !i_stall
//   o_cyc      bus cycle, identical to o_stb
//   o_stb      request strobe, held stable until accepted
//   o_we       constant 1 (every request is a write)
//   o_btn      debounced button level
//   o_dropped  one-cycle pulse: a press arrived while a request was pending
//              and could not be queued
//   o_count    8-bit count of accepted requests, wraps 255 -> 0
//
// Parameters:
//   DEBOUNCE_CLKS  consecutive cycles the synchronized input must disagree
//                  with o_btn before o_btn flips (>= 2)
//   REPEAT_CLKS    auto-repeat period in cycles (>= 2), auto-repeat only
//
// Build option:
//   BTNREQ_AUTOREPEAT_EN  when defined, holding the button generates an extra
//                         press every REPEAT_CLKS cycles after the o_btn rise.
//                         When undefined no repeat logic exists.
// -----------------------------------------------------------------------------
module button_request #(
  parameter int unsigned DEBOUNCE_CLKS = 1_000_000,
  parameter int unsigned REPEAT_CLKS   = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn,
  input  logic       i_stall,
  output logic       o_cyc,
  output logic       o_stb,
  output logic       o_we,
  output logic       o_btn,
  output logic       o_dropped,
  output logic [7:0] o_count
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int unsigned CW = $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CLKS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // ---------------------------------------------------------------------------
  // Synchronizer: i_btn is asynchronous, so it passes through two flops before
  // any logic looks at it. sync_q is i_btn delayed by two edges.
  // ---------------------------------------------------------------------------
  logic sync_meta_q;
  logic sync_q;

  // NOTE: every register, including the synchronizer and the counters, has an
  // asynchronous reset so that asserting i_reset clears the whole pipeline at
  // once, even between clock edges. Sequential blocks use non-blocking (<=)
  // assignments only, so all flops sample pre-edge values and the order of
  // statements inside a block does not matter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= i_btn;
      sync_q      <= sync_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Integrating debouncer. The counter measures how long the synchronized
  // input has disagreed with the debounced level; any agreement restarts it.
  // The level flips on the DEBOUNCE_CLKS-th consecutive disagreeing cycle, so
  // the counter never goes beyond DEB_LAST.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          btn_q, btn_d;

  // NOTE: each always_comb assigns every output a default value before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    btn_d     = btn_q;
    if (sync_q == btn_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      btn_d     = sync_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      deb_cnt_q <= '0;
      btn_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      btn_q     <= btn_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press detection. btn_prev_q lags btn_q by one cycle; btn_rise is high in
  // the single cycle where the debounced level has just gone 0 -> 1. The press
  // itself is registered, so the FSM sees a clean one-cycle pulse.
  // ---------------------------------------------------------------------------
  logic btn_prev_q;
  logic btn_rise;
  logic press_d;
  logic press_q;

  assign btn_rise = btn_q & ~btn_prev_q;

`ifdef BTNREQ_AUTOREPEAT_EN
  // Auto-repeat: the repeat counter starts from zero on the cycle after the
  // rise and reloads each time it fires, so presses land on the rise and then
  // exactly every REPEAT_CLKS cycles while the debounced level stays high.
  localparam int unsigned RW = (REPEAT_CLKS > 1) ? $clog2(REPEAT_CLKS) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CLKS - 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_hit;

  assign rpt_hit = btn_q && (rpt_cnt_q == RPT_LAST);

  always_comb begin
    rpt_cnt_d = rpt_cnt_q + RW'(1);
    if (!btn_q || btn_rise || rpt_hit) begin
      rpt_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign press_d = btn_rise | rpt_hit;
`else
  // Only a debounced rising edge counts as a press. REPEAT_CLKS is still
  // referenced here so the parameter stays part of the interface.
  logic unused_repeat_clks;
  assign unused_repeat_clks = (REPEAT_CLKS > 1);
  assign press_d = btn_rise;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      btn_prev_q <= btn_q;
      press_q    <= press_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM. IDLE waits for a press; REQ drives the strobe until the
  // walker accepts it. A press arriving together with an accept immediately
  // starts the next request; a press arriving while stalled is lost and
  // reported on o_dropped.
  // ---------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       dropped_q, dropped_d;
  logic       stb;
  logic       accept;

  assign stb    = (state_q == ST_REQ);
  assign accept = stb && !i_stall;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dropped_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_q) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (accept) begin
          // The 8-bit add wraps 255 -> 0 naturally.
          count_d = count_q + 8'd1;
          if (!press_q) begin
            state_d = ST_IDLE;
          end
        end else if (press_q) begin
          dropped_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_stb     = stb;
  assign o_cyc     = stb;
  assign o_we      = 1'b1;
  assign o_btn     = btn_q;
  assign o_dropped = dropped_q;
  assign o_count   = count_q;

endmodule

// File: tb/tb_button_request.sv
// -----------------------------------------------------------------------------
// tb_button_request
//
// Directed bench for button_request with DEBOUNCE_CLKS=4, REPEAT_CLKS=10.
// Stimulus runs relative to a cycle marker (mark); the driver pushes the
// expected accepts (cycle, count afterwards) and drop pulses into queues, and
// an independent negedge monitor pops and compares whenever the DUT accepts
// a request or pulses o_dropped.
// -----------------------------------------------------------------------------
module tb_button_request;

  localparam int unsigned DEB = 4;
  localparam int unsigned RPT = 10;

  logic       clk;
  logic       i_reset;
  logic       i_btn;
  logic       i_stall;
  logic       o_cyc;
  logic       o_stb;
  logic       o_we;
  logic       o_btn;
  logic       o_dropped;
  logic [7:0] o_count;

  button_request #(
    .DEBOUNCE_CLKS (DEB),
    .REPEAT_CLKS   (RPT)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_btn     (i_btn),
    .i_stall   (i_stall),
    .o_cyc     (o_cyc),
    .o_stb     (o_stb),
    .o_we      (o_we),
    .o_btn     (o_btn),
    .o_dropped (o_dropped),
    .o_count   (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter; cyc - mark is the cycle number within a test.
  int cyc  = 0;
  int mark = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int rel_cyc;
    int cnt_after;
  } acc_t;

  acc_t exp_acc[$];
  int   exp_drop[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the posedge that makes the relative cycle n.
  task automatic goto_edge(input int n);
    int k;
    k = cyc - mark;
    repeat (n - k) @(posedge clk);
    #1;
  endtask

  // Advance to the negedge inside relative cycle n.
  task automatic goto_neg(input int n);
    int k;
    k = cyc - mark;
    repeat (n - k) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_acc(input int rel, input int cnt);
    acc_t e;
    e.rel_cyc   = rel;
    e.cnt_after = cnt;
    exp_acc.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic cnt_pending = 1'b0;
  int   cnt_exp     = 0;
  logic prev_stb    = 1'b0;
  logic prev_acc    = 1'b0;

  always @(negedge clk) begin
    if (i_reset) begin
      cnt_pending = 1'b0;
      prev_stb    = 1'b0;
      prev_acc    = 1'b0;
    end else begin
      if (cnt_pending) begin
        check("count_after_accept", o_count, cnt_exp);
        cnt_pending = 1'b0;
      end
      if (prev_stb && !o_stb) begin
        check("stb_fall_needs_accept", prev_acc, 1);
      end
      if (o_stb && !i_stall) begin
        if (exp_acc.size() == 0) begin
          check("accept_expected", exp_acc.size(), 1);
        end else begin
          acc_t e;
          e = exp_acc.pop_front();
          check("accept_cycle", cyc - mark, e.rel_cyc);
          check("cyc_eq_stb", o_cyc, o_stb);
          cnt_exp     = e.cnt_after;
          cnt_pending = 1'b1;
        end
      end
      if (o_dropped) begin
        check("dropped_implies_stb", o_stb, 1);
        if (exp_drop.size() == 0) begin
          check("drop_expected", exp_drop.size(), 1);
        end else begin
          check("drop_cycle", cyc - mark, exp_drop.pop_front());
        end
      end
      prev_stb = o_stb;
      prev_acc = o_stb && !i_stall;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    i_btn   = 1'b0;
    i_stall = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    #1;
    check("rst_stb", o_stb, 0);
    check("rst_cyc", o_cyc, 0);
    check("rst_btn", o_btn, 0);
    check("rst_dropped", o_dropped, 0);
    check("rst_count", o_count, 0);
    check("we_const", o_we, 1);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    mark    = cyc;
  endtask

  task automatic end_test(input string name);
    repeat (3) @(negedge clk);
    check({name, "_acc_left"}, exp_acc.size(), 0);
    check({name, "_drop_left"}, exp_drop.size(), 0);
    exp_acc.delete();
    exp_drop.delete();
  endtask

  // Watchdog: the directed flow is clock-counted, this only guards a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int final_cnt;
    i_reset = 1'b1;
    i_btn   = 1'b0;
    i_stall = 1'b0;

    // 1. Clean press: o_btn at 6, single strobe at 8, count 1.
    do_reset();
    i_btn = 1'b1;
    push_acc(8, 1);
    goto_neg(5);  check("t1_btn_before", o_btn, 0);
    goto_neg(6);  check("t1_btn_rise", o_btn, 1);
    goto_neg(7);  check("t1_stb_early", o_stb, 0);
    goto_neg(8);  check("t1_stb", o_stb, 1);
    goto_neg(9);  check("t1_stb_one_cycle", o_stb, 0);
    goto_edge(10); i_btn = 1'b0;
    goto_neg(13); check("t1_btn_held", o_btn, 1);
                  check("t1_no_restrobe", o_stb, 0);
    goto_neg(16); check("t1_btn_release", o_btn, 0);
    goto_neg(22); check("t1_count", o_count, 1);
                  check("t1_stb_idle", o_stb, 0);
    end_test("t1");

    // 2. Bounce shorter than the debounce window is ignored.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      goto_edge(2 * i + 1);
      i_btn = (i % 2 == 0);
      goto_neg(2 * i + 2);
      check("t2_btn_stays_low", o_btn, 0);
    end
    goto_edge(21); i_btn = 1'b0;
    goto_neg(35); check("t2_btn", o_btn, 0);
                  check("t2_count", o_count, 0);
    end_test("t2");

    // 3. Stall: strobe held 9 cycles, accepted once stall drops.
    do_reset();
    i_stall = 1'b1;
    i_btn   = 1'b1;
    push_acc(16, 1);
    goto_edge(8);  i_btn = 1'b0;
    goto_neg(12);  check("t3_stb_held", o_stb, 1);
                   check("t3_count_stalled", o_count, 0);
    goto_edge(16); i_stall = 1'b0;
    goto_neg(17);  check("t3_stb_dropped", o_stb, 0);
    goto_neg(22);  check("t3_count", o_count, 1);
    end_test("t3");

    // 4. Second press while stalled is dropped; one accept afterwards.
    do_reset();
    i_stall = 1'b1;
    i_btn   = 1'b1;
    exp_drop.push_back(24);
    push_acc(34, 1);
    goto_edge(8);  i_btn = 1'b0;
    goto_neg(12);  check("t4_stb_held", o_stb, 1);
    goto_edge(16); i_btn = 1'b1;
    goto_neg(22);  check("t4_btn_second", o_btn, 1);
    goto_edge(26); i_btn = 1'b0;
    goto_neg(30);  check("t4_stb_still", o_stb, 1);
    goto_edge(34); i_stall = 1'b0;
    goto_neg(40);  check("t4_count", o_count, 1);
                   check("t4_stb_idle", o_stb, 0);
    end_test("t4");

    // 5. Reset mid-request clears state asynchronously; held button re-presses.
    do_reset();
    i_btn = 1'b1;
    push_acc(8, 1);
    goto_edge(8);  i_btn = 1'b0;
    goto_edge(16); i_btn = 1'b1; i_stall = 1'b1;
    goto_neg(25);  check("t5_stb_pending", o_stb, 1);
                   check("t5_count_pre", o_count, 1);
    goto_edge(26); i_reset = 1'b1;
    #1;
    check("t5_async_stb", o_stb, 0);
    check("t5_async_cyc", o_cyc, 0);
    check("t5_async_btn", o_btn, 0);
    check("t5_async_count", o_count, 0);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_stall = 1'b0;
    mark    = cyc;
    push_acc(8, 1);
    goto_neg(5);  check("t5_btn_before", o_btn, 0);
    goto_neg(6);  check("t5_btn_rise", o_btn, 1);
    goto_edge(8); i_btn = 1'b0;
    goto_neg(20); check("t5_count", o_count, 1);
    end_test("t5");

    // 6. Long hold: auto-repeat gives strobes at 8, 18, 28 when enabled.
    do_reset();
    i_btn = 1'b1;
    push_acc(8, 1);
`ifdef BTNREQ_AUTOREPEAT_EN
    push_acc(18, 2);
    push_acc(28, 3);
    final_cnt = 3;
`else
    final_cnt = 1;
`endif
    goto_edge(30); i_btn = 1'b0;
    goto_neg(50);  check("t6_count", o_count, final_cnt);
                   check("t6_btn", o_btn, 0);
    end_test("t6");

    // 7. 256 accepted presses wrap o_count back to 0.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      mark  = cyc;
      i_btn = 1'b1;
      push_acc(8, (k + 1) % 256);
      goto_edge(8);
      i_btn = 1'b0;
      goto_edge(16);
    end
    goto_neg(20); check("t7_count_wrap", o_count, 0);
    end_test("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
